// File: rtl/mux_arbiter.sv
// Round-robin arbiter and select sequencer for a 4-input, two-level mux.
// Four requesters (req[0..3] -> a, b, c, d) compete for the mux output. The
// arbiter holds each grant for at most MAX_HOLD cycles, drives the matching
// {select_group, select} code, and leaves one idle cycle between grants.
module mux_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       select,
    output logic       select_group,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, stateNext;
    logic [1:0] ptr, ptrNext;
    logic [1:0] own, ownNext;
    logic [7:0] cnt, cntNext;
    logic [3:0] gntNext;
    logic       selectNext, selectGroupNext;
    logic [1:0] winner;

    // Rotating priority search: the lowest offset from ptr with a request wins.
    // Scanning from the far end lets the nearest hit overwrite the others.
    always_comb begin
        winner = ptr;
        for (int unsigned k = 4; k > 0; k--) begin
            if (req[ptr + 2'(k - 1)]) begin
                winner = ptr + 2'(k - 1);
            end
        end
    end

    // Next-state and next-output logic; selects only move when a grant loads.
    always_comb begin
        stateNext       = state;
        ptrNext         = ptr;
        ownNext         = own;
        cntNext         = cnt;
        gntNext         = gnt;
        selectNext      = select;
        selectGroupNext = select_group;
        case (state)
            IDLE, GAP: begin
                stateNext = IDLE;
                gntNext   = '0;
                if (en && (req != '0)) begin
                    stateNext       = GRANT;
                    ownNext         = winner;
                    gntNext         = 4'b0001 << winner;
                    selectGroupNext = winner[1];
                    selectNext      = winner[0];
                    cntNext         = '0;
                end
            end
            GRANT: begin
                if (!req[own] || (cnt == HOLD_LAST)) begin
                    stateNext = GAP;
                    gntNext   = '0;
                    ptrNext   = own + 2'd1;
                end else begin
                    cntNext = cnt + 8'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                gntNext   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            own          <= '0;
            cnt          <= '0;
            gnt          <= '0;
            select       <= 1'b0;
            select_group <= 1'b0;
        end else begin
            state        <= stateNext;
            ptr          <= ptrNext;
            own          <= ownNext;
            cnt          <= cntNext;
            gnt          <= gntNext;
            select       <= selectNext;
            select_group <= selectGroupNext;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and select sequencer for the 4-input, two-level gate multiplexer (inputs a, b, c, d, with select choosing within a group and select_group choosing the group). Four requesters compete for the shared mux output. The arbiter grants one requester at a time, drives the mux select lines for that requester, and holds each grant for a bounded time. A one-cycle dead gap is inserted between grants so downstream logic never sees two owners back to back.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles a grant is held. Legal range 1..255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  when low, no new grant is issued; a grant already in progress runs to completion.
- req  input  4  request lines. req[0]→a, req[1]→b, req[2]→c, req[3]→d.
- gnt  output  4  registered one-hot grant; all zeros when no requester owns the mux.
- select  output  1  registered mux select within the group.
- select_group  output  1  registered mux group select.
- busy  output  1  high while in GRANT or GAP.

## Operation
- Select encoding, {select_group, select}: requester 0 = 00 (a), 1 = 01 (b), 2 = 10 (c), 3 = 11 (d).
- Internal state:
  - ptr: 2 bits, round-robin start point.
  - cnt: 8 bits, hold counter.
  - own: 2 bits, current owner.
- Winner selection: the first index i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- States:
  - IDLE → GRANT when en=1 and req≠0. Load own=winner, gnt=one-hot(own), selects=enc(own), cnt=0.
  - GRANT, each cycle: if req[own]=0 or cnt==MAX_HOLD-1, go to GAP, set gnt=0 and ptr=own+1 (mod 4). Otherwise cnt=cnt+1.
  - GAP, exactly one cycle, gnt=0, selects keep their last value. Then go to GRANT (same load rule as IDLE) if en=1 and req≠0, else go to IDLE.
- Requests from non-owners during GRANT are ignored until the next arbitration.
- en going low during GRANT does not cut the grant short; it only blocks the next arbitration.
- A requester that keeps req high after its grant expires is skipped in favour of any other active requester (ptr moves past it). It can be re-granted immediately only if it is the sole requester.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Outputs: gnt=0000, select=0, select_group=0, busy=0.
  - Internal: state=IDLE, ptr=0, cnt=0, own=0.
- Arbitration latency: req sampled at edge N. gnt, selects and busy valid after edge N (one cycle).
- Selects change only at the edge that asserts a new gnt. They never change while gnt≠0.
- Maximum hold: gnt high for exactly MAX_HOLD cycles with req held. With MAX_HOLD=1, every grant lasts one cycle.
- Release: req[own] low sampled at edge N causes gnt=0 after edge N.
- Gap: always exactly one cycle with gnt=0 between two grants, including re-grant of the same requester.
- Simultaneous events:
  - Owner drops req on the same edge its cnt expires: a single transition to GAP.
  - All four req rise together from IDLE with ptr=0: requester 0 wins.
- Reset mid-GRANT: gnt clears asynchronously. The first grant after reset release follows the ptr=0 priority.

## Test plan
- Reset: assert reset mid-GRANT with gnt=0100 → gnt=0000, select=0, select_group=0, busy=0 immediately. After release with req=1111, first gnt=0001.
- Single requester: req=1000 held, MAX_HOLD=4 → gnt=1000 for 4 cycles, {select_group,select}=11; then 1 gap cycle; then gnt=1000 again.
- Round-robin rotation: req=1111 held → gnt sequence 0001, 0010, 0100, 1000, 0001, each grant 4 cycles, one gap cycle between grants, selects 00, 01, 10, 11.
- Early release: req=0011, owner 0 drops req after 2 cycles → gnt=0001 for 2 cycles, gap, then gnt=0010 with select=1, select_group=0.
- Enable: en=0 with req=0110 → gnt stays 0000 and busy=0. Drop en to 0 during a grant to requester 1 → grant completes, then GAP→IDLE.
- MAX_HOLD=1 with req=0101 → gnt alternates 0001, 0000, 0100, 0000, each state lasting one cycle.
